// File: rtl/bounce_emulator.sv
// Contact-bounce generator: each accepted level change on clean becomes a burst of glitches, then a settle hold.
// Optional build macro BOUNCE_FIXED_WIDTH_EN makes every glitch/hold phase exactly MIN_W cycles wide.
module bounce_emulator #(
    parameter int          BOUNCES = 4,
    parameter int          MIN_W   = 2,
    parameter int          W_BITS  = 4,
    parameter int          SETTLE  = 16,
    parameter int          CBITS   = 8,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic clk,
    input  logic reset,
    input  logic clean,
    input  logic bypass,
    output logic bouncy,
    output logic busy
);

    localparam int RBITS = (BOUNCES < 1) ? 1 : $clog2(BOUNCES + 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        GLITCH,
        SETTLE_ST
    } state_e;

    state_e             state_q, state_d;
    logic               level_q, level_d;
    logic               bouncy_q, bouncy_d;
    logic               busy_q, busy_d;
    logic [CBITS-1:0]   cnt_q, cnt_d;
    logic [RBITS-1:0]   rem_q, rem_d;
    logic [CBITS-1:0]   phase_load;

`ifdef BOUNCE_FIXED_WIDTH_EN
    assign phase_load = CBITS'(MIN_W - 1);
`else
    logic [15:0] lfsr_q, lfsr_d;

    // Galois LFSR, taps 0xB400; the current value sizes any phase loaded this cycle.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign phase_load = CBITS'(MIN_W - 1) + CBITS'(lfsr_q[W_BITS-1:0]);
`endif

    // NOTE: every signal gets its hold value first, so no path through this block can infer a latch.
    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        bouncy_d = bouncy_q;
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;

        if (bypass) begin
            state_d  = IDLE;
            level_d  = clean;
            bouncy_d = clean;
            busy_d   = 1'b0;
            cnt_d    = '0;
            rem_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (clean != level_q) begin
                        level_d  = clean;
                        bouncy_d = clean;
                        busy_d   = 1'b1;
                        rem_d    = RBITS'(BOUNCES);
                        if (BOUNCES == 0) begin
                            cnt_d   = CBITS'(SETTLE - 1);
                            state_d = SETTLE_ST;
                        end else begin
                            cnt_d   = phase_load;
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        bouncy_d = ~level_q;
                        cnt_d    = phase_load;
                        state_d  = GLITCH;
                    end else begin
                        cnt_d = cnt_q - CBITS'(1);
                    end
                end
                GLITCH: begin
                    if (cnt_q == '0) begin
                        bouncy_d = level_q;
                        rem_d    = rem_q - RBITS'(1);
                        if (rem_q == RBITS'(1)) begin
                            cnt_d   = CBITS'(SETTLE - 1);
                            state_d = SETTLE_ST;
                        end else begin
                            cnt_d   = phase_load;
                            state_d = HOLD;
                        end
                    end else begin
                        cnt_d = cnt_q - CBITS'(1);
                    end
                end
                SETTLE_ST: begin
                    if (cnt_q == '0) begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CBITS'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: non-blocking assignments keep every flop sampling the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            level_q  <= 1'b0;
            bouncy_q <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            rem_q    <= '0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            bouncy_q <= bouncy_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
        end
    end

    assign bouncy = bouncy_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_bounce_emulator.sv
// Directed bench for bounce_emulator: bursts, ignored mid-burst change, bypass, async reset.
// Phase widths come from an independent LFSR model (or MIN_W when BOUNCE_FIXED_WIDTH_EN is defined).
module tb_bounce_emulator;

    localparam int          BOUNCES = 2;
    localparam int          MIN_W   = 3;
    localparam int          W_BITS  = 4;
    localparam int          SETTLE  = 8;
    localparam int          CBITS   = 8;
    localparam logic [15:0] SEED    = 16'hACE1;

    logic clk = 1'b0;
    logic reset;
    logic clean;
    logic bypass;
    logic bouncy;
    logic busy;

    int checks = 0;
    int errors = 0;
    logic [15:0] m_lfsr;

    always #5 clk = ~clk;

    bounce_emulator #(
        .BOUNCES(BOUNCES),
        .MIN_W  (MIN_W),
        .W_BITS (W_BITS),
        .SETTLE (SETTLE),
        .CBITS  (CBITS),
        .SEED   (SEED)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .clean (clean),
        .bypass(bypass),
        .bouncy(bouncy),
        .busy  (busy)
    );

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic int width_of(input logic [15:0] v);
`ifdef BOUNCE_FIXED_WIDTH_EN
        return MIN_W;
`else
        return MIN_W + int'(v[W_BITS-1:0]);
`endif
    endfunction

    // Reference LFSR, free-running exactly like the one the widths are drawn from.
    always @(posedge clk or negedge reset) begin
        if (!reset) m_lfsr <= SEED;
        else        m_lfsr <= lfsr_step(m_lfsr);
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Call with clean already driven and the next posedge being the sampling edge (cycle 0).
    // Checks cycles 1..end-of-settle+1; optionally changes clean at cycle toggle_at.
    task automatic burst(input logic lvl, input int toggle_at, input logic toggle_val);
        int         bnd[0:2*BOUNCES];
        logic [15:0] cur;
        int         idx;
        int         total;
        logic       exp_b;
        logic       exp_y;
        cur    = m_lfsr;
        idx    = 0;
        bnd[0] = 0;
        for (int k = 0; k < 2 * BOUNCES; k++) begin
            while (idx < bnd[k]) begin
                cur = lfsr_step(cur);
                idx++;
            end
            bnd[k+1] = bnd[k] + width_of(cur);
        end
        total = bnd[2*BOUNCES] + SETTLE;
        @(posedge clk);
        for (int c = 1; c <= total + 1; c++) begin
            #1;
            exp_y = lvl;
            for (int k = 1; k < 2 * BOUNCES; k += 2) begin
                if (c > bnd[k] && c <= bnd[k+1]) exp_y = ~lvl;
            end
            exp_b = (c <= total);
            check($sformatf("burst%0b_bouncy_c%0d", lvl, c), bouncy, exp_y);
            check($sformatf("burst%0b_busy_c%0d", lvl, c), busy, exp_b);
            if (c == toggle_at) clean = toggle_val;
            if (c <= total) @(posedge clk);
        end
    endtask

    initial begin
        logic [3:0] pat;
        pat    = 4'b0110;
        reset  = 1'b0;
        clean  = 1'b0;
        bypass = 1'b0;
        #12;
        check("reset_bouncy", bouncy, 1'b0);
        check("reset_busy", busy, 1'b0);

        // First clean=1 after reset release is an edge.
        @(negedge clk);
        reset = 1'b1;
        clean = 1'b1;
        burst(1'b1, 0, 1'b0);

        // Falling burst; clean flips back at cycle 5 and must be ignored until IDLE.
        clean = 1'b0;
        burst(1'b0, 5, 1'b1);
        // The re-compare in IDLE launches the rising burst on the very next edge.
        burst(1'b1, 0, 1'b0);
        clean = 1'b0;
        burst(1'b0, 0, 1'b0);

        // Bypass asserted at cycle 6 of a rising burst.
        clean = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            #1;
            if (c <= 3) check($sformatf("byp_pre_bouncy_c%0d", c), bouncy, 1'b1);
            check($sformatf("byp_pre_busy_c%0d", c), busy, 1'b1);
            if (c == 6) bypass = 1'b1;
            @(posedge clk);
        end
        #1;
        check("byp_c7_bouncy", bouncy, 1'b1);
        check("byp_c7_busy", busy, 1'b0);
        for (int i = 0; i < 4; i++) begin
            clean = pat[i];
            @(posedge clk);
            #1;
            check($sformatf("byp_follow_bouncy_%0d", i), bouncy, pat[i]);
            check($sformatf("byp_follow_busy_%0d", i), busy, 1'b0);
        end
        // Release bypass with clean equal to level: no burst.
        bypass = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("byp_release_bouncy_%0d", i), bouncy, 1'b0);
            check($sformatf("byp_release_busy_%0d", i), busy, 1'b0);
        end

        // Async reset between edges during a rising burst.
        clean = 1'b1;
        @(posedge clk);
        repeat (8) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("async_rst_bouncy", bouncy, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        @(negedge clk);
        check("rst_hold_bouncy", bouncy, 1'b0);
        check("rst_hold_busy", busy, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        burst(1'b1, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bounce_emulator.md
Name: bounce_emulator

Overview:
- Generates a realistic contact-bounce waveform from a clean logic level. It is the transmit-side counterpart of the switch debouncer.
- Each accepted level change on the input produces a burst of glitches with pseudo-random widths, then the output settles at the new level.
- Used in on-board loopback and simulation to stress debouncer instances with repeatable bounce patterns.

Parameters:
- BOUNCES, 4: number of glitches (returns to the old level) per edge; 0 = clean edge followed by settle.
- MIN_W, 2: minimum phase width in clk cycles; must be >= 1.
- W_BITS, 4: random span; phase width = MIN_W + lfsr[W_BITS-1:0], giving MIN_W .. MIN_W+2^W_BITS-1.
- SETTLE, 16: cycles the output is held stable at the new level after the last glitch; must be >= 1.
- CBITS, 8: width of the phase/settle down-counter; must hold max(MIN_W+2^W_BITS-1, SETTLE).
- SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (reset = 0 resets the block).
- clean  in  1  ideal input level, synchronous to clk.
- bypass  in  1  1 = output follows clean with no bounce.
- bouncy  out  1  emulated bouncing signal, registered.
- busy  out  1  1 while a burst or settle is in progress.

Behaviour:
- Reset (reset low, async): state IDLE, level = 0, bouncy = 0, busy = 0, counter = 0, lfsr = SEED. The first clean = 1 after reset release is treated as an edge.
- LFSR: 16-bit Galois, taps 16'hB400, shifts every clk cycle while out of reset. The sample value is read in the same cycle the counter is loaded.
- Counter: a phase is loaded with width-1 and counts down. The phase ends on the cycle the counter is 0.
- States:
  - IDLE: bouncy = level, busy = 0. If clean != level and bypass = 0:
    - level <= clean, bouncy <= clean, busy <= 1, remaining <= BOUNCES, load counter.
    - Go to HOLD, or to SETTLE (counter = SETTLE-1) if BOUNCES = 0.
  - HOLD: bouncy = level. At count 0: bouncy <= ~level, load counter, go to GLITCH.
  - GLITCH: bouncy = ~level. At count 0: bouncy <= level, decrement remaining.
    - If remaining was 1: counter <= SETTLE-1, go to SETTLE.
    - Otherwise: load counter, go to HOLD.
  - SETTLE: bouncy = level, busy = 1. At count 0: busy <= 0, go to IDLE.
- Latency: bouncy first changes one clk after the clean change is sampled. Total burst length = sum of 2*BOUNCES phase widths + SETTLE cycles.
- clean changes during HOLD/GLITCH/SETTLE are ignored (not queued). On return to IDLE, clean is re-compared with level; if they differ, a new burst starts on the next clk.
- bypass = 1 in any state: next clk → IDLE, level <= clean, bouncy <= clean, busy <= 0, counter cleared. While bypass = 1, bouncy tracks clean with 1-cycle latency.
- bypass falling while clean == level: stay IDLE, no burst.
- Reset asserted mid-burst: immediate return to the reset values above.
- Counter never wraps: every load value is <= 2^CBITS-1 by the parameter rule.

Optional Feature:
- Macro: BOUNCE_FIXED_WIDTH_EN.
- Defined: every HOLD/GLITCH width is exactly MIN_W. The LFSR is not built, and SEED and W_BITS are ignored. The waveform is fully deterministic.
- Undefined: widths are random as described in Behaviour.
- All other behaviour (settle, bypass, ignoring changes mid-burst) is identical in both builds.

Test Plan:
- Setup for all scenarios: BOUNCE_FIXED_WIDTH_EN defined, BOUNCES=2, MIN_W=3, SETTLE=8, clk cycles numbered from the edge that samples the change.
- Basic rising edge: clean 0→1 sampled at cycle 0 → bouncy = 1 on cycles 1-3, 0 on 4-6, 1 on 7-9, 0 on 10-12, 1 from 13 on. busy = 1 on cycles 1-20, 0 at 21.
- Change mid-burst: clean 1→0 at cycle 5 during a rising burst → waveform as in the basic case through cycle 20. New falling burst starts with bouncy = 0 at cycle 22; busy = 1 again from cycle 22.
- Bypass: bypass = 1 at cycle 6 of a burst → bouncy = clean and busy = 0 from cycle 7. Toggling clean while bypass = 1 shows bouncy = clean delayed 1 cycle, with no glitches.
- Async reset: reset = 0 at cycle 9 between clk edges → bouncy = 0 and busy = 0 immediately. After release with clean = 1, a full rising burst is reproduced.
- Random build (macro undefined, SEED=16'hACE1, W_BITS=4): every HOLD/GLITCH width is in 3..18. Exactly 2 glitches per edge. Feeding bouncy into a debouncer with COUNT > 18 gives one clean transition per clean edge.
